timer_tc: RTL and testbench
===========================

Name: timer_tc

Overview:
- Memory-mapped programmable countdown timer on the system bridge.
- Its interrupt line is one bit of the 6-bit hardware-interrupt vector consumed by the coprocessor-0 exception/interrupt block.
- The CPU programs it through store/load words. It reloads a preset, counts down once per clock, and raises `irq` on expiry in one-shot or auto-reload mode.

Parameters:
- BASE, 32'h0000_7F00, word-aligned base address; the block decodes offsets 0x0, 0x4 and 0x8.
- CNT_W, 32, width of PRESET and COUNT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from the bridge; bits [1:0] ignored.
- we  in  1  write strobe, qualified by a decoded address hit.
- din  in  32  write data.
- dout  out  32  read data, combinational on `addr`.
- irq  out  1  interrupt request to coprocessor-0 `HWInt`, bit 2 by system convention.

Behaviour:
- Register map:
  - BASE+0 is CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x behaves as 00), bit3 IM (interrupt mask). Bits[31:4] read 0.
  - BASE+4 is PRESET, read/write.
  - BASE+8 is COUNT, read-only; writes are ignored.
- Address hit: addr[31:4] == BASE[31:4] and addr[3:2] < 3. Reads of other addresses return 0.
- Reset (asynchronous): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, so `irq`=0. Reset mid-count aborts immediately.
- `irq` = CTRL.IM & irq_flag, combinational from registers.
- Writes take effect at the clock edge. The FSM in the same cycle evaluates the pre-write CTRL.
- Any write to CTRL or PRESET clears irq_flag.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT; irq_flag <= 0.
  - CNT:
    - If !EN, go to IDLE and freeze COUNT.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else (COUNT <= 1), COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - MODE 00: EN <= 0, go to IDLE; irq_flag held until a CTRL/PRESET write.
    - MODE 01: irq_flag <= 0, go to IDLE with EN still 1, so it reloads automatically. `irq` is a 1-cycle pulse.
- Boundary cases:
  - PRESET=0 or 1: expires on the first CNT cycle.
  - COUNT never wraps below 0.
  - A PRESET write during CNT does not affect the current count; it is used at the next LOAD.
- Simultaneous events:
  - A CPU write to CTRL.EN in the same cycle that INT clears EN in mode 00: the CPU write wins.
  - A CTRL/PRESET write in the same cycle that CNT sets irq_flag: the set wins.
- Latency: with PRESET=N≥1 and EN written at edge t0, `irq` rises after edge t0+N+2.

Decomposition:
- Shared package holds:
  - CTRL bit positions (EN=0, MODE=2:1, IM=3).
  - Register offsets 0x0/0x4/0x8.
  - FSM state encoding (2 bits).
  - Timer IRQ index (2) in the `HWInt` vector.
- No sub-module: register file, decode and FSM fit one module. The top-level bridge instantiates it and routes `irq` to `HWInt[2]`.

Test Plan:
1. Reset asserted mid-count (COUNT=3): COUNT, CTRL, PRESET and `irq` read 0 immediately, without waiting for a clock edge.
2. One-shot: PRESET=5, CTRL=0x9 at t0. COUNT reads 5,4,3,2,1 over t2..t6. `irq`=1 from t7 and stays high; CTRL reads 0x8 after t8. Writing CTRL=0x8 drops `irq` after the next edge.
3. Auto-reload: PRESET=3, CTRL=0xB. `irq` is a 1-cycle pulse repeating every 6 cycles (3+3); EN stays 1.
4. Masked: CTRL=0x1, PRESET=2. irq_flag sets but `irq` stays 0. A later write of CTRL=0x8 clears the flag, and `irq` remains 0.
5. Disable mid-count: PRESET=10, enable, write CTRL=0x8 at COUNT=6. COUNT freezes at 6, no `irq`. Re-enabling reloads COUNT to 10.
6. Bus: a write to COUNT is ignored; reads of BASE+0xC and out-of-window addresses return 0; PRESET=0 expires after the first CNT cycle.

Source files
------------

// File: rtl/timer_tc_pkg.sv
// Shared definitions for the countdown timer: CTRL bit positions, register
// word offsets, FSM state encoding and the timer's slot in the HWInt vector.
// Imported by the interface-facing timer block and by the system bridge.
package timer_tc_pkg;

    // CTRL register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // Register word offsets (addr[3:2]); byte offsets 0x0, 0x4, 0x8
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // Only 01 selects auto-reload; 00 and 1x both behave as one-shot
    localparam logic [1:0] MODE_AUTO = 2'b01;

    // Bit of the coprocessor-0 HWInt vector driven by this timer
    localparam int TIMER_IRQ_IDX = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_tc_if.sv
// Bridge-side bus for the timer: word address, write strobe/data, read data
// and the interrupt line. master = bridge/CPU side, slave = timer.
// Signals: addr[31:0], we, din[31:0] (to timer); dout[31:0], irq (from timer).
interface timer_tc_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_tc.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT FSM, irq.
// Latency: EN written at edge t0 with PRESET=N>=1 -> irq high after edge t0+N+2; reads combinational.
// Backpressure: none; every bus access completes in the cycle it is presented.
// Ports: clk, reset (async active-high), bus (slave: addr, we, din in; dout, irq out).
module timer_tc
    import timer_tc_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_7F00,
    parameter int          CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    timer_tc_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [CNT_W-1:0]    r_preset;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                r_flag;
    logic                w_flag_nxt;
    logic                w_en_clr;

    logic                w_hit;
    logic                w_wr_ctrl;
    logic                w_wr_preset;
    logic                w_auto;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // Byte lanes are not used: all accesses are whole words
    assign w_unused = &{1'b0, bus.addr[1:0]};

    // Window is 16 bytes but only the first three words are decoded
    assign w_hit       = (bus.addr[31:4] == BASE[31:4]) && (bus.addr[3:2] != 2'd3);
    assign w_wr_ctrl   = bus.we && w_hit && (bus.addr[3:2] == REG_CTRL);
    assign w_wr_preset = bus.we && w_hit && (bus.addr[3:2] == REG_PRESET);
    assign w_auto      = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (bus.addr[3:2])
                REG_CTRL:   w_rdata = 32'(r_ctrl);
                REG_PRESET: w_rdata = 32'(r_preset);
                REG_COUNT:  w_rdata = 32'(r_count);
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.dout = w_rdata;
    assign bus.irq  = r_ctrl[CTRL_IM] & r_flag;

    // FSM sees the pre-write CTRL. A CTRL/PRESET write clears the flag,
    // but the CNT expiry below overrides it so a coincident set wins.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flag_nxt  = (w_wr_ctrl || w_wr_preset) ? 1'b0 : r_flag;
        w_en_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ctrl[CTRL_EN]) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_flag_nxt  = 1'b0;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl[CTRL_EN]) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_count_nxt = r_count - CNT_W'(1);
                end else begin
                    // Covers PRESET 0 and 1; COUNT never wraps
                    w_count_nxt = '0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (w_auto) begin
                    // EN stays set, so IDLE immediately starts a reload
                    w_flag_nxt = 1'b0;
                end else begin
                    w_en_clr = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_flag  <= w_flag_nxt;
            // CPU write of CTRL takes priority over the one-shot EN clear
            if (w_wr_ctrl) begin
                r_ctrl <= bus.din[CTRL_W-1:0];
            end else if (w_en_clr) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= bus.din[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_timer_tc.sv
// Directed bench for timer_tc: reset, one-shot, auto-reload, masking,
// disable/re-enable, bus decode, PRESET=0 and simultaneous-event cases.
// Expected values are hand-derived cycle counts relative to the enabling write edge.
module tb_timer_tc;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    timer_tc_if bus ();

    timer_tc #(.BASE(BASE), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a write that lands on the next rising edge; returns 1 time unit after it
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        bus.addr = BASE;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        d = bus.dout;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.addr = BASE;
        bus.din  = 32'd0;
        #3;
        for (int i = 0; i < 3; i++) begin
            rd(BASE + 32'(i * 4), v);
            total++;
            if (v !== 32'd0) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, v, 32'd0);
            end
        end
        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", bus.irq);
        end
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(BASE + 32'h4, 32'd5);
        wr(BASE, 32'h9);                // edge t0
        step(1);                        // t1: LOAD
        step(1);                        // t2: COUNT=5
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'h8, v);
            total++;
            if (v !== 32'(5 - i) || bus.irq !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_count t%0d got=%0d irq=%b exp=%0d irq=0", i + 2, v, bus.irq, 5 - i);
            end
            step(1);
        end
        // now after t7
        total++;
        if (bus.irq !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_irq_rise got=%b exp=1", bus.irq);
        end
        step(1);                        // t8
        rd(BASE, v);
        total++;
        if (v !== 32'h8) begin
            bad++;
            $display("FAIL oneshot_ctrl_en_clr got=%h exp=%h", v, 32'h8);
        end
        step(3);
        total++;
        if (bus.irq !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_irq_held got=%b exp=1", bus.irq);
        end
        wr(BASE, 32'h8);
        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_irq_clear got=%b exp=0", bus.irq);
        end
    endtask

    task automatic test_auto;
        logic [31:0] v;
        logic        exp;
        wr(BASE + 32'h4, 32'd3);
        wr(BASE, 32'hB);                // t0
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp = (k == 5) || (k == 11) || (k == 17);
            total++;
            if (bus.irq !== exp) begin
                bad++;
                $display("FAIL auto_irq t%0d got=%b exp=%b", k, bus.irq, exp);
            end
        end
        rd(BASE, v);
        total++;
        if (v !== 32'hB) begin
            bad++;
            $display("FAIL auto_ctrl got=%h exp=%h", v, 32'hB);
        end
        wr(BASE, 32'h8);
        step(2);
    endtask

    task automatic test_masked;
        logic [31:0] v;
        wr(BASE + 32'h4, 32'd2);
        wr(BASE, 32'h1);                // t0; flag sets at t4, EN cleared at t5
        for (int k = 1; k <= 6; k++) begin
            step(1);
            total++;
            if (bus.irq !== 1'b0) begin
                bad++;
                $display("FAIL masked_irq t%0d got=%b exp=0", k, bus.irq);
            end
        end
        rd(BASE, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL masked_ctrl got=%h exp=%h", v, 32'h0);
        end
        // Unmasking with the same write must also clear the pending flag
        wr(BASE, 32'h8);
        step(1);
        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL masked_unmask_irq got=%b exp=0", bus.irq);
        end
    endtask

    task automatic test_disable;
        logic [31:0] v;
        wr(BASE + 32'h4, 32'd10);
        wr(BASE, 32'h9);                // t0
        step(5);                        // t5
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd7) begin
            bad++;
            $display("FAIL disable_pre got=%0d exp=7", v);
        end
        wr(BASE, 32'h8);                // lands t6: last decrement to 6
        step(1);
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'h8, v);
            total++;
            if (v !== 32'd6 || bus.irq !== 1'b0) begin
                bad++;
                $display("FAIL disable_frozen k%0d got=%0d irq=%b exp=6 irq=0", k, v, bus.irq);
            end
            step(1);
        end
        wr(BASE, 32'h9);                // t0'
        step(2);
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd10) begin
            bad++;
            $display("FAIL disable_reload got=%0d exp=10", v);
        end
        step(1);
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd9) begin
            bad++;
            $display("FAIL disable_recount got=%0d exp=9", v);
        end
        wr(BASE, 32'h8);                // t0'+4: count 8, then IDLE
        step(2);
    endtask

    task automatic test_bus;
        logic [31:0] v;
        wr(BASE + 32'h8, 32'h1234);
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd8) begin
            bad++;
            $display("FAIL bus_count_ro got=%h exp=%h", v, 32'd8);
        end
        wr(32'h0000_7F14, 32'h55);
        rd(BASE + 32'h4, v);
        total++;
        if (v !== 32'd10) begin
            bad++;
            $display("FAIL bus_oow_write got=%h exp=%h", v, 32'd10);
        end
        rd(BASE + 32'hC, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL bus_rd_c got=%h exp=0", v);
        end
        rd(32'h0000_7F10, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL bus_rd_oow got=%h exp=0", v);
        end
        rd(32'h0000_0004, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL bus_rd_low got=%h exp=0", v);
        end
        rd(BASE + 32'h6, v);
        total++;
        if (v !== 32'd10) begin
            bad++;
            $display("FAIL bus_byte_ignored got=%h exp=%h", v, 32'd10);
        end
        rd(BASE, v);
        total++;
        if (v !== 32'h8) begin
            bad++;
            $display("FAIL bus_ctrl got=%h exp=%h", v, 32'h8);
        end
    endtask

    task automatic test_preset_zero;
        logic [31:0] v;
        wr(BASE + 32'h4, 32'd0);
        wr(BASE, 32'h9);                // t0
        step(2);                        // t2
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd0 || bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL pz_load got=%0d irq=%b exp=0 irq=0", v, bus.irq);
        end
        step(1);                        // t3
        total++;
        if (bus.irq !== 1'b1) begin
            bad++;
            $display("FAIL pz_irq got=%b exp=1", bus.irq);
        end
        // CPU sets EN on the same edge the one-shot INT clears it
        wr(BASE, 32'h9);                // t4
        rd(BASE, v);
        total++;
        if (v !== 32'h9 || bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL pz_cpu_wins got=%h irq=%b exp=%h irq=0", v, bus.irq, 32'h9);
        end
        step(2);                        // t6: CNT with COUNT=0
        // PRESET write on the expiry edge: flag set must win
        wr(BASE + 32'h4, 32'd0);        // t7
        total++;
        if (bus.irq !== 1'b1) begin
            bad++;
            $display("FAIL pz_set_wins got=%b exp=1", bus.irq);
        end
        wr(BASE, 32'h8);                // t8
        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL pz_final_clear got=%b exp=0", bus.irq);
        end
        step(2);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(BASE + 32'h4, 32'd5);
        wr(BASE, 32'h9);                // t0
        step(4);                        // t4: COUNT=3
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd3) begin
            bad++;
            $display("FAIL rmid_pre got=%0d exp=3", v);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL rmid_irq got=%b exp=0", bus.irq);
        end
        for (int i = 0; i < 3; i++) begin
            rd(BASE + 32'(i * 4), v);
            total++;
            if (v !== 32'd0) begin
                bad++;
                $display("FAIL rmid_reg%0d got=%h exp=0", i, v);
            end
        end
        step(2);
        reset = 1'b0;
        step(3);
        rd(BASE + 32'h8, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL rmid_post_count got=%0d exp=0", v);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_oneshot();
        test_auto();
        test_masked();
        test_disable();
        test_bus();
        test_preset_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
